// File: rtl/mem_arbiter_pkg.sv
// Shared types for the main-memory arbiter: FSM state encoding and grant owner.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Build option MEM_ARB_RR_EN is consumed by mem_arb_picker.
package mem_arbiter_pkg;

    localparam int MEMARB_ADDR_W  = 10;
    localparam int MEMARB_BLOCK_W = 256;

    typedef enum logic [1:0] {
        MEMARB_IDLE  = 2'b00,
        MEMARB_OWN_D = 2'b01,
        MEMARB_OWN_I = 2'b10
    } memarb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_arb_picker.sv
// Picks the next owner from the I/D requests; holds only the build-dependent policy.
// Latency: combinational.
// Backpressure: none; MEM_ARB_RR_EN selects round-robin, otherwise D has fixed priority.
import mem_arbiter_pkg::*;

module mem_arb_picker (
    input  logic   reqI,
    input  logic   reqD,
    input  grant_t lastGrant,
    output grant_t winner
);

`ifdef MEM_ARB_RR_EN
    // Round-robin: on a tie the side that did not own memory last goes first.
    always_comb begin
        winner = lastGrant;
        if (reqI && reqD) begin
            winner = (lastGrant == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (reqD) begin
            winner = GRANT_D;
        end else if (reqI) begin
            winner = GRANT_I;
        end
    end
`else
    // Fixed priority: D always wins; with no request the answer is unused, so hold lastGrant.
    always_comb begin
        winner = lastGrant;
        if (reqD) begin
            winner = GRANT_D;
        end else if (reqI) begin
            winner = GRANT_I;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares the main-memory block port between I-cache refill and D-cache writeback/refill.
// Latency: grant 1 cycle after request in IDLE; memory signals then pass through combinationally.
// Backpressure: owner keeps the grant while its request is high; MEM_ARB_RR_EN picks round-robin.
import mem_arbiter_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W  = MEMARB_ADDR_W,
    parameter int BLOCK_W = MEMARB_BLOCK_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iRen,
    input  logic [ADDR_W-1:0]  iAddr,
    output logic               iReadReady,
    input  logic               dRen,
    input  logic               dWen,
    input  logic [ADDR_W-1:0]  dAddr,
    input  logic [BLOCK_W-1:0] dDin,
    output logic               dReadReady,
    output logic               dWriteDone,
    output logic [BLOCK_W-1:0] blkDout,
    output logic               memRen,
    output logic               memWen,
    output logic [ADDR_W-1:0]  memAddr,
    output logic [BLOCK_W-1:0] memDin,
    input  logic               memReadReady,
    input  logic               memWriteDone,
    input  logic [BLOCK_W-1:0] memDout
);

    memarb_state_t state_q, state_d;
    grant_t        last_grant_q, last_grant_d;
    grant_t        winner;
    logic          req_i, req_d;

    assign req_i = iRen;
    assign req_d = dRen | dWen;

    mem_arb_picker u_picker (
        .reqI      (req_i),
        .reqD      (req_d),
        .lastGrant (last_grant_q),
        .winner    (winner)
    );

    // Next owner: arbitrate from IDLE, otherwise hold until the owner drops its request.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            MEMARB_IDLE: begin
                if (req_i || req_d) begin
                    state_d = (winner == GRANT_D) ? MEMARB_OWN_D : MEMARB_OWN_I;
                end
            end
            MEMARB_OWN_D: begin
                if (!req_d) begin
                    state_d      = req_i ? MEMARB_OWN_I : MEMARB_IDLE;
                    last_grant_d = GRANT_D;
                end
            end
            MEMARB_OWN_I: begin
                if (!req_i) begin
                    state_d      = req_d ? MEMARB_OWN_D : MEMARB_IDLE;
                    last_grant_d = GRANT_I;
                end
            end
            default: state_d = MEMARB_IDLE;
        endcase
    end

    // Owner and last-grant registers; async reset drops ownership immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= MEMARB_IDLE;
            last_grant_q <= GRANT_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Output muxes: forward the owner's request, route completions back to the owner only.
    always_comb begin
        memRen     = 1'b0;
        memWen     = 1'b0;
        memAddr    = '0;
        memDin     = '0;
        iReadReady = 1'b0;
        dReadReady = 1'b0;
        dWriteDone = 1'b0;
        case (state_q)
            MEMARB_OWN_D: begin
                // A simultaneous read and write forwards the writeback only.
                memRen     = dRen & ~dWen;
                memWen     = dWen;
                memAddr    = dAddr;
                memDin     = dDin;
                dReadReady = memReadReady;
                dWriteDone = memWriteDone;
            end
            MEMARB_OWN_I: begin
                memRen     = iRen;
                memAddr    = iAddr;
                iReadReady = memReadReady;
            end
            default: ;
        endcase
    end

    assign blkDout = memDout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cycle table, async-reset cases, random vs model.
// Latency: n/a.
// Backpressure: n/a. Expectations follow MEM_ARB_RR_EN if defined for the build.
module tb_mem_arbiter;

    localparam int AW = 10;
    localparam int BW = 256;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          iRen, dRen, dWen;
    logic [AW-1:0] iAddr, dAddr;
    logic [BW-1:0] dDin, memDout;
    logic          memReadReady, memWriteDone;
    logic          iReadReady, dReadReady, dWriteDone;
    logic [BW-1:0] blkDout, memDin;
    logic          memRen, memWen;
    logic [AW-1:0] memAddr;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW)) dut (
        .clock        (clock),
        .reset        (reset),
        .iRen         (iRen),
        .iAddr        (iAddr),
        .iReadReady   (iReadReady),
        .dRen         (dRen),
        .dWen         (dWen),
        .dAddr        (dAddr),
        .dDin         (dDin),
        .dReadReady   (dReadReady),
        .dWriteDone   (dWriteDone),
        .blkDout      (blkDout),
        .memRen       (memRen),
        .memWen       (memWen),
        .memAddr      (memAddr),
        .memDin       (memDin),
        .memReadReady (memReadReady),
        .memWriteDone (memWriteDone),
        .memDout      (memDout)
    );

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against an expected set.
    task automatic chk_all(input string tag, input logic e_ren, input logic e_wen,
                           input logic [AW-1:0] e_addr, input logic [BW-1:0] e_din,
                           input logic e_irr, input logic e_drr, input logic e_dwd);
        chk({tag, ".memRen"},     BW'(memRen),     BW'(e_ren));
        chk({tag, ".memWen"},     BW'(memWen),     BW'(e_wen));
        chk({tag, ".memAddr"},    BW'(memAddr),    BW'(e_addr));
        chk({tag, ".memDin"},     memDin,          e_din);
        chk({tag, ".iReadReady"}, BW'(iReadReady), BW'(e_irr));
        chk({tag, ".dReadReady"}, BW'(dReadReady), BW'(e_drr));
        chk({tag, ".dWriteDone"}, BW'(dWriteDone), BW'(e_dwd));
        chk({tag, ".blkDout"},    blkDout,         memDout);
    endtask

    // Directed cycle table: inputs {iRen,dRen,dWen,memReadReady,memWriteDone}, outputs expected
    // before the next edge: {memRen,memWen}, memAddr, memDin==dDin, {iReady,dReady,dDone}.
    typedef struct {
        logic [4:0]    in;
        logic [1:0]    ew;
        logic [AW-1:0] addr;
        logic          din_d;
        logic [2:0]    rdy;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] in, input logic [1:0] ew,
                                input logic [AW-1:0] addr, input logic din_d, input logic [2:0] rdy);
        vec_t v;
        v.in = in; v.ew = ew; v.addr = addr; v.din_d = din_d; v.rdy = rdy;
        return v;
    endfunction

    // Reference model: owner 0 = none, 1 = I, 2 = D; last is the most recent releaser.
    int m_owner;
    int m_last;

    function automatic int pick(input logic ri, input logic rd, input int last);
        if (ri && rd) return RR ? ((last == 1) ? 2 : 1) : 2;
        return rd ? 2 : 1;
    endfunction

    task automatic model_step;
        logic ri, rd;
        ri = iRen;
        rd = dRen | dWen;
        if (m_owner == 0) begin
            if (ri || rd) m_owner = pick(ri, rd, m_last);
        end else if (m_owner == 2 && !rd) begin
            m_last  = 2;
            m_owner = ri ? 1 : 0;
        end else if (m_owner == 1 && !ri) begin
            m_last  = 1;
            m_owner = rd ? 2 : 0;
        end
    endtask

    task automatic model_check(input string tag);
        case (m_owner)
            2: chk_all(tag, dRen & ~dWen, dWen, dAddr, dDin, 1'b0, memReadReady, memWriteDone);
            1: chk_all(tag, iRen, 1'b0, iAddr, '0, memReadReady, 1'b0, 1'b0);
            default: chk_all(tag, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        endcase
    endtask

    vec_t vecs[19];
    logic [BW-1:0] pat_dead, pat_cafe;

    initial begin
        pat_dead = {16{16'hDEAD}};
        pat_cafe = {16{16'hCAFE}};

        vecs[0]  = mk(5'b11000, 2'b00, 10'h000, 1'b0, 3'b000);
        vecs[1]  = mk(5'b11000, 2'b10, 10'h2A5, 1'b1, 3'b000);
        vecs[2]  = mk(5'b10100, 2'b01, 10'h2A5, 1'b1, 3'b000);
        vecs[3]  = mk(5'b10101, 2'b01, 10'h2A5, 1'b1, 3'b001);
        vecs[4]  = mk(5'b11000, 2'b10, 10'h2A5, 1'b1, 3'b000);
        vecs[5]  = mk(5'b11010, 2'b10, 10'h2A5, 1'b1, 3'b010);
        vecs[6]  = mk(5'b10000, 2'b00, 10'h2A5, 1'b1, 3'b000);
        vecs[7]  = mk(5'b10000, 2'b10, 10'h013, 1'b0, 3'b000);
        vecs[8]  = mk(5'b10010, 2'b10, 10'h013, 1'b0, 3'b100);
        vecs[9]  = mk(5'b00000, 2'b00, 10'h013, 1'b0, 3'b000);
        vecs[10] = mk(5'b00010, 2'b00, 10'h000, 1'b0, 3'b000);
        vecs[11] = mk(5'b01000, 2'b00, 10'h000, 1'b0, 3'b000);
        vecs[12] = mk(5'b01000, 2'b10, 10'h2A5, 1'b1, 3'b000);
        vecs[13] = mk(5'b00000, 2'b00, 10'h2A5, 1'b1, 3'b000);
        vecs[14] = mk(5'b11000, 2'b00, 10'h000, 1'b0, 3'b000);
        vecs[15] = mk(5'b11000, 2'b10, RR ? 10'h013 : 10'h2A5, !RR, 3'b000);
        vecs[16] = mk(5'b01000, RR ? 2'b00 : 2'b10, RR ? 10'h013 : 10'h2A5, !RR, 3'b000);
        vecs[17] = mk(5'b01000, 2'b10, 10'h2A5, 1'b1, 3'b000);
        vecs[18] = mk(5'b00000, 2'b00, 10'h2A5, 1'b1, 3'b000);

        // Reset held with both requests and a stray completion: everything stays 0.
        reset = 1'b0;
        iRen = 1'b1; dRen = 1'b1; dWen = 1'b0;
        iAddr = 10'h013; dAddr = 10'h2A5; dDin = pat_dead; memDout = pat_cafe;
        memReadReady = 1'b1; memWriteDone = 1'b1;
        #2;
        chk_all("reset_hold", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        @(posedge clock); #1;
        chk_all("reset_edge", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        memReadReady = 1'b0; memWriteDone = 1'b0;
        reset = 1'b1;

        // Directed table, one row per clock cycle.
        for (int k = 0; k < 19; k++) begin
            {iRen, dRen, dWen, memReadReady, memWriteDone} = vecs[k].in;
            @(negedge clock);
            chk_all($sformatf("vec%0d", k), vecs[k].ew[1], vecs[k].ew[0], vecs[k].addr,
                    vecs[k].din_d ? pat_dead : '0,
                    vecs[k].rdy[2], vecs[k].rdy[1], vecs[k].rdy[0]);
            @(posedge clock); #1;
        end

        // Async reset in the middle of an I refill: memRen drops without a clock edge.
        {iRen, dRen, dWen, memReadReady, memWriteDone} = 5'b10000;
        @(posedge clock); #2;
        chk("midI.memRen_before", BW'(memRen), BW'(1'b1));
        chk("midI.memAddr_before", BW'(memAddr), BW'(10'h013));
        reset = 1'b0;
        #1;
        chk_all("midI_reset", 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        iRen = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;

        // Randomized traffic against the reference model.
        m_owner = 0;
        m_last  = 1;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) iRen = ~iRen;
            if ($urandom_range(0, 3) == 0) dRen = ~dRen;
            if ($urandom_range(0, 4) == 0) dWen = ~dWen;
            iAddr = AW'($urandom);
            dAddr = AW'($urandom);
            for (int w = 0; w < BW / 32; w++) begin
                dDin[w*32 +: 32]    = $urandom;
                memDout[w*32 +: 32] = $urandom;
            end
            memReadReady = ($urandom_range(0, 3) == 0);
            memWriteDone = ($urandom_range(0, 3) == 0);
            @(negedge clock);
            model_check($sformatf("rnd%0d", c));
            @(posedge clock);
            model_step();
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
